// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// funct3 operation encodings and the controller state type.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath. {hi,lo} is the working pair:
// multiply keeps the partial product in hi and the unconsumed multiplier in lo;
// divide keeps the partial remainder in hi and the dividend/quotient in lo.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Add-shift for multiply, compare-subtract-shift (restoring) for divide.
    // The borrow out of the XLEN+1-bit subtraction is the "does not fit" flag.
    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        shifted = {hi_i, lo_i[XLEN-1]};
        diff    = shifted - {1'b0, b_i};
        if (is_div_i) begin
            if (!diff[XLEN]) begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shifted[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: magnitudes are iterated one bit per
// cycle, the sign is applied when the last step completes.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | ready for a request
//   CALC    | iterating, cnt_q counts remaining steps (XLEN-1 .. 0)
//   DONE    | result held on result_o until the consumer takes it
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;

    logic [XLEN-1:0]   st_hi, st_lo;
    logic              sa, sb, is_div, div0, ovf;
    logic [XLEN-1:0]   a_mag, b_mag, bypass_res, fin_res;
    logic [2*XLEN-1:0] prod_fix;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (st_hi),
        .lo_o     (st_lo)
    );

    // Operand decode at acceptance: magnitudes, result sign and fast-path cases.
    always_comb begin
        is_div = funct3_i[2];
        sa     = rs1_i[XLEN-1] && (funct3_i == F3_MUL || funct3_i == F3_MULH ||
                 funct3_i == F3_MULHSU || funct3_i == F3_DIV || funct3_i == F3_REM);
        sb     = rs2_i[XLEN-1] && (funct3_i == F3_MUL || funct3_i == F3_MULH ||
                 funct3_i == F3_DIV || funct3_i == F3_REM);
        a_mag  = sa ? -rs1_i : rs1_i;
        b_mag  = sb ? -rs2_i : rs2_i;
        div0   = is_div && (rs2_i == '0);
        ovf    = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
                 (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        if (div0) begin
            bypass_res = funct3_i[1] ? rs1_i : '1;
        end else begin
            bypass_res = funct3_i[1] ? '0 : rs1_i;
        end
    end

    // Sign correction of the final iteration output; remainder follows dividend.
    always_comb begin
        prod_fix = neg_q ? -{st_hi, st_lo} : {st_hi, st_lo};
        case (op_q)
            F3_MUL:          fin_res = prod_fix[XLEN-1:0];
            F3_DIV, F3_DIVU: fin_res = neg_q ? -st_lo : st_lo;
            F3_REM, F3_REMU: fin_res = neg_q ? -st_hi : st_hi;
            default:         fin_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // Next-state and datapath update; flush overrides everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        op_d    = op_q;
        neg_d   = neg_q;
        res_d   = res_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            res_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        op_d  = funct3_i;
                        neg_d = (is_div && funct3_i[1]) ? sa : (sa ^ sb);
                        hi_d  = '0;
                        lo_d  = is_div ? a_mag : b_mag;
                        b_d   = is_div ? b_mag : a_mag;
                        if (div0 || ovf) begin
                            state_d = ST_DONE;
                            res_d   = bypass_res;
                        end else begin
                            state_d = ST_CALC;
                            cnt_d   = CW'(XLEN - 1);
                        end
                    end
                end
                ST_CALC: begin
                    hi_d = st_hi;
                    lo_d = st_lo;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        res_d   = fin_res;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_d = ST_IDLE;
                        res_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign busy_o   = (state_q != ST_IDLE);
    assign result_o = valid_o ? res_q : '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (XLEN=32): results, latency, hold, flush, reset.
module tb_muldiv_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request; the accepting edge is edge 1, and valid_o must first
    // be seen after edge exp_lat. Then consume the result.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk_i);
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
        valid_i  = 1'b1;
        funct3_i = f;
        rs1_i    = a;
        rs2_i    = b;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        rs1_i   = '0;
        rs2_i   = '0;
        n = 1;
        while (!valid_o && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, 64'(result_o), 64'(exp_res));
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        chk({tag, "_consumed"}, {62'd0, valid_o, ready_o}, 64'd1);
        chk({tag, "_res_zero"}, 64'(result_o), 64'd0);
    endtask

    initial begin
        int  n;
        bit  saw_valid;
        logic [31:0] held;

        #1;
        chk("reset_outputs", {60'd0, ready_o, valid_o, busy_o, 1'b0}, 64'b1000);
        chk("reset_result", 64'(result_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op("mul_7_m3",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu_min",    3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu_m1",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mulhu_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mul_shift",    3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
        run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("divu_100_7",   3'b101, 32'd100,      32'd7,         32'd14,        33);
        run_op("remu_100_7",   3'b111, 32'd100,      32'd7,         32'd2,         33);
        run_op("divu_max_1",   3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33);
        run_op("divu_by0",     3'b101, 32'h8000_0000, 32'd0,        32'hFFFF_FFFF, 1);
        run_op("div_by0",      3'b100, 32'd5,        32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_by0",     3'b111, 32'h0000_1234, 32'd0,        32'h0000_1234, 1);
        run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Result held with ready_i low for five cycles.
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'b100; rs1_i = 32'd100; rs2_i = 32'hFFFF_FFF6;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("hold_lat", 64'(n), 64'd33);
        held = result_o;
        chk("hold_first", 64'(held), 64'hFFFF_FFF6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("hold_flags", {61'd0, valid_o, ready_o, busy_o}, 64'b101);
            chk("hold_result", 64'(result_o), 64'(held));
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        chk("hold_release", {62'd0, valid_o, ready_o}, 64'd1);

        // Flush at the tenth CALC cycle drops the operation.
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd9; rs2_i = 32'd9;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        for (int i = 0; i < 9; i++) @(posedge clk_i);
        @(negedge clk_i);
        chk("flush_busy_before", {62'd0, busy_o, valid_o}, 64'b10);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        chk("flush_idle", {61'd0, ready_o, busy_o, valid_o}, 64'b100);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) saw_valid = 1'b1;
        end
        chk("flush_no_valid", 64'(saw_valid), 64'd0);
        run_op("after_flush",  3'b000, 32'd6,        32'd7,         32'd42,        33);

        // Reset mid-CALC discards the operation asynchronously.
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        for (int i = 0; i < 14; i++) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_flags", {61'd0, ready_o, busy_o, valid_o}, 64'b100);
        chk("rst_mid_result", 64'(result_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) saw_valid = 1'b1;
        end
        chk("rst_no_valid", 64'(saw_valid), 64'd0);
        run_op("after_rst",    3'b111, 32'd1000,     32'd3,         32'd1,         33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
